// File: rtl/periph_bus_master_pkg.sv
// Shared types and constants for the peripheral bus master: FSM states, command word layout,
// bus constants and the default request timeout.
package periph_bus_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } bm_state_e;

    localparam int CMD_W = 65;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    localparam logic        RstEnable   = 1'b0;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bm_cmd_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/periph_bus_master_cmd_fifo.sv
// Synchronous command FIFO for the bus master; first-word-fall-through read port.
// Storage is not reset: only the pointers define what is valid.
module bm_cmd_fifo
    import periph_bus_master_pkg::*;
#(
    parameter int WIDTH = CMD_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/periph_bus_master.sv
// Peripheral register bus initiator: queues commands, issues them one at a time, one response each.
// Optional BUS_MASTER_TIMEOUT_EN: error response after TIMEOUT_CYCLES in REQ without ack.
module periph_bus_master
    import periph_bus_master_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        ack_i
);

    bm_state_e   state_q;
    logic        req_q, we_q;
    logic [31:0] addr_q, wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;

    logic        fifo_full, fifo_empty, fifo_pop;
    bm_cmd_t     push_cmd, head_cmd;
    logic [CMD_W-1:0] head_raw;

    assign push_cmd = '{we: cmd_we_i, addr: cmd_addr_i, data: cmd_data_i};
    assign head_cmd = bm_cmd_t'(head_raw);

    // Held low while reset is asserted so every output reads 0 during reset.
    assign cmd_ready_o = !fifo_full && (rst != RstEnable);

    // Pop whenever the FSM is free to start the next command (IDLE, or RSP handshake).
    assign fifo_pop = !fifo_empty &&
                      ((state_q == ST_IDLE) || (state_q == ST_RSP && rsp_ready_i));

    bm_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid_i && cmd_ready_o),
        .wdata_i (CMD_W'(push_cmd)),
        .pop_i   (fifo_pop),
        .rdata_o (head_raw),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_q;
    logic        rsp_err_q;
    logic        timeout;

    // wait_q equals the number of completed REQ cycles; the last allowed one times out.
    assign timeout   = (state_q == ST_REQ) && !ack_i && (wait_q >= TO_LAST);
    assign rsp_err_o = rsp_err_q;
`else
    logic timeout;
    assign timeout   = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= ZeroWord;
            wdata_q     <= ZeroWord;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= ZeroWord;
`ifdef BUS_MASTER_TIMEOUT_EN
            wait_q      <= 16'd0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        we_q    <= head_cmd.we;
                        addr_q  <= head_cmd.addr;
                        wdata_q <= head_cmd.data;
`ifdef BUS_MASTER_TIMEOUT_EN
                        wait_q  <= 16'd0;
`endif
                    end
                end
                ST_REQ: begin
                    if (ack_i || timeout) begin
                        state_q     <= ST_RSP;
                        req_q       <= 1'b0;
                        we_q        <= 1'b0;
                        addr_q      <= ZeroWord;
                        wdata_q     <= ZeroWord;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= (ack_i && we_q != WriteEnable) ? data_i : ZeroWord;
`ifdef BUS_MASTER_TIMEOUT_EN
                        rsp_err_q   <= !ack_i;
                    end else begin
                        wait_q      <= sat_inc16(wait_q);
`endif
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= ZeroWord;
`ifdef BUS_MASTER_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        if (fifo_pop) begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                            we_q    <= head_cmd.we;
                            addr_q  <= head_cmd.addr;
                            wdata_q <= head_cmd.data;
`ifdef BUS_MASTER_TIMEOUT_EN
                            wait_q  <= 16'd0;
`endif
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_o       = req_q;
    assign we_o        = we_q;
    assign addr_o      = addr_q;
    assign data_o      = wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_periph_bus_master.sv
// Directed bench for periph_bus_master: write/read, back-to-back queueing, response stall,
// timeout (when BUS_MASTER_TIMEOUT_EN is defined) and mid-transaction reset.
module tb_periph_bus_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_i = 1'b0, cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0, cmd_data_i = '0;
    logic        cmd_ready_o;
    logic        rsp_valid_o, rsp_err_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        req_o, we_o;
    logic [31:0] addr_o, data_o;
    logic [31:0] data_i = '0;
    logic        ack_i = 1'b0;

    int n_chk = 0;
    int n_bad = 0;

    periph_bus_master #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o),
        .data_i(data_i), .ack_i(ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one command, wait (bounded) for ready, let it be accepted on the next edge.
    task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d);
        int w;
        w = 0;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = a; cmd_data_i = d;
        while (!cmd_ready_o && w < 50) begin
            tick;
            w++;
        end
        chk("push_ready", cmd_ready_o, 1);
        tick;
        cmd_valid_i = 1'b0;
    endtask

    task automatic rsp_take;
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
    endtask

    logic [31:0] exp_addr [5];
    logic        exp_we   [5];

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #10;
        chk("rst_req", req_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_cmd_ready", cmd_ready_o, 0);
        chk("rst_addr", addr_o, 0);
        @(negedge clk) rst = 1'b1;
        tick;
        chk("rel_cmd_ready", cmd_ready_o, 1);
        chk("rel_rsp_valid", rsp_valid_o, 0);

        // Write 3 to 0x0
        push(1'b1, 32'h0, 32'h3);
        chk("wr_req_lat0", req_o, 0);
        tick;
        chk("wr_req", req_o, 1);
        chk("wr_we", we_o, 1);
        chk("wr_addr", addr_o, 32'h0);
        chk("wr_data", data_o, 32'h3);
        tick;
        chk("wr_req_hold", req_o, 1);
        chk("wr_rsp_early", rsp_valid_o, 0);
        tick;
        ack_i = 1'b1; data_i = 32'hDEAD_BEEF;
        tick;
        ack_i = 1'b0; data_i = '0;
        chk("wr_req_drop", req_o, 0);
        chk("wr_we_drop", we_o, 0);
        chk("wr_rsp_valid", rsp_valid_o, 1);
        chk("wr_rsp_data", rsp_data_o, 0);
        chk("wr_rsp_err", rsp_err_o, 0);
        rsp_take;
        chk("wr_rsp_done", rsp_valid_o, 0);

        // Read 0x8 with ack in the first REQ cycle
        push(1'b0, 32'h8, 32'h0);
        tick;
        chk("rd_req", req_o, 1);
        chk("rd_we", we_o, 0);
        chk("rd_addr", addr_o, 32'h8);
        ack_i = 1'b1; data_i = 32'h0000_00FF;
        tick;
        ack_i = 1'b0; data_i = '0;
        chk("rd_rsp_valid", rsp_valid_o, 1);
        chk("rd_rsp_data", rsp_data_o, 32'h0000_00FF);
        chk("rd_rsp_err", rsp_err_o, 0);
        rsp_take;

        // Five commands queued, then drained back-to-back
        for (int k = 0; k < 5; k++) begin
            exp_addr[k] = 32'h100 + 32'(k * 4);
            exp_we[k]   = (k == 2);
        end
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) push(exp_we[k], exp_addr[k], 32'hCAFE_0000 + 32'(k));
        chk("q_full_ready", cmd_ready_o, 0);
        for (int k = 0; k < 5; k++) begin
            chk("q_req", req_o, 1);
            chk("q_addr", addr_o, exp_addr[k]);
            chk("q_we", we_o, 32'(exp_we[k]));
            ack_i = 1'b1; data_i = 32'hD000 + 32'(k);
            tick;
            ack_i = 1'b0; data_i = '0;
            chk("q_rsp_valid", rsp_valid_o, 1);
            chk("q_rsp_data", rsp_data_o, exp_we[k] ? 32'h0 : 32'hD000 + 32'(k));
            tick;
            if (k == 0) chk("q_ready_again", cmd_ready_o, 1);
        end
        rsp_ready_i = 1'b0;
        chk("q_idle_req", req_o, 0);
        chk("q_idle_rsp", rsp_valid_o, 0);

        // Response stalled 20 cycles with a command waiting; stray acks ignored
        push(1'b0, 32'h20, 32'h0);
        tick;
        ack_i = 1'b1; data_i = 32'h1234;
        tick;
        data_i = 32'hFFFF_FFFF;
        push(1'b1, 32'h24, 32'h55);
        for (int i = 0; i < 20; i++) begin
            chk("stall_valid", rsp_valid_o, 1);
            chk("stall_data", rsp_data_o, 32'h1234);
            chk("stall_err", rsp_err_o, 0);
            chk("stall_req", req_o, 0);
            tick;
        end
        ack_i = 1'b0; data_i = '0;
        rsp_take;
        chk("stall_next_req", req_o, 1);
        chk("stall_next_addr", addr_o, 32'h24);
        chk("stall_next_we", we_o, 1);
        ack_i = 1'b1;
        tick;
        ack_i = 1'b0;
        chk("stall_next_data", rsp_data_o, 0);
        rsp_take;

`ifdef BUS_MASTER_TIMEOUT_EN
        // Read with no ack: error after TO REQ cycles; late ack ignored
        push(1'b0, 32'h30, 32'h0);
        tick;
        for (int i = 0; i < TO; i++) begin
            chk("to_req", req_o, 1);
            tick;
        end
        chk("to_req_drop", req_o, 0);
        chk("to_rsp_valid", rsp_valid_o, 1);
        chk("to_rsp_err", rsp_err_o, 1);
        chk("to_rsp_data", rsp_data_o, 0);
        ack_i = 1'b1; data_i = 32'h9999;
        tick;
        ack_i = 1'b0; data_i = '0;
        chk("to_late_err", rsp_err_o, 1);
        chk("to_late_data", rsp_data_o, 0);
        rsp_take;
        // Ack in the last allowed cycle wins
        push(1'b0, 32'h34, 32'h0);
        tick;
        for (int i = 0; i < TO - 1; i++) tick;
        chk("to_edge_req", req_o, 1);
        ack_i = 1'b1; data_i = 32'h77;
        tick;
        ack_i = 1'b0; data_i = '0;
        chk("to_edge_err", rsp_err_o, 0);
        chk("to_edge_data", rsp_data_o, 32'h77);
        rsp_take;
`else
        // No timeout: REQ waits for ack indefinitely
        push(1'b0, 32'h30, 32'h0);
        tick;
        for (int i = 0; i < 20; i++) begin
            chk("wait_req", req_o, 1);
            tick;
        end
        chk("wait_rsp", rsp_valid_o, 0);
        ack_i = 1'b1; data_i = 32'h99;
        tick;
        ack_i = 1'b0; data_i = '0;
        chk("wait_err", rsp_err_o, 0);
        chk("wait_data", rsp_data_o, 32'h99);
        rsp_take;
`endif

        // Reset mid-REQ with a second command still queued
        push(1'b0, 32'h40, 32'h0);
        push(1'b1, 32'h44, 32'h1);
        chk("mrst_req_before", req_o, 1);
        #2 rst = 1'b0;
        #1;
        chk("mrst_req", req_o, 0);
        chk("mrst_we", we_o, 0);
        chk("mrst_addr", addr_o, 0);
        chk("mrst_rsp", rsp_valid_o, 0);
        @(negedge clk) rst = 1'b1;
        tick;
        chk("mrst_ready", cmd_ready_o, 1);
        tick;
        tick;
        chk("mrst_no_issue", req_o, 0);
        chk("mrst_no_rsp", rsp_valid_o, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
